// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, muldiv modes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Iterative unit mode select
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) / divider (restoring), one bit per step.
// Latency: WIDTH steps after load; lo/hi show the post-step value, so the final result is visible while last is high.
// Backpressure: none; caller drives step every cycle it wants progress.
// Ports: load/mode/A/B start an operation; step advances; lo = product/quotient, hi = remainder; last = final step pending.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             step,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             last
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;

    always_comb begin
        // MUL: {hi,lo} is the partial product with the multiplier shifting out of lo.
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        // DIV: shift the next dividend bit into the partial remainder; bit WIDTH of diff is the borrow.
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_q};

        hi_d   = hi_q;
        lo_d   = lo_q;
        b_d    = b_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (load) begin
            hi_d   = '0;
            lo_d   = A;
            b_d    = B;
            mode_d = mode;
            cnt_d  = CW'(WIDTH);
        end else if (step && (cnt_q != '0)) begin
            if (mode_q == MODE_DIV) begin
                // Divisor 0 never borrows: quotient fills with ones and the remainder collects A.
                hi_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            mode_q <= MODE_MUL;
            cnt_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lo   = lo_d;
    assign hi   = hi_d;
    assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake; optional iterative MUL/DIVU/REMU (macro ALU_MULDIV_EN).
// Latency: 1 cycle for single-cycle ops and illegal codes; WIDTH+1 cycles for MUL/DIVU/REMU.
// Backpressure: start is sampled only in IDLE; start during RUN or DONE is dropped.
// Ports: clk/rst (sync, active high); start/op/A/B request; busy, done pulse; res, Co, zero, overflow, illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             Co,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d, co_q, co_d, zero_q, zero_d;
    logic             ovf_q, ovf_d, ill_q, ill_d;

    logic [WIDTH-1:0] b_eff, alu_res;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic             is_sub, alu_co, alu_ovf, alu_ill;

    // Single-cycle datapath straight off the request inputs; the result register is the operand latch.
    always_comb begin
        is_sub  = (op == OP_SUB);
        b_eff   = is_sub ? ~B : B;
        sum     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        shamt   = B[SHW-1:0];
        alu_res = '0;
        alu_co  = 1'b0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOR:  alu_res = ~(A | B);
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_co  = sum[WIDTH];
                alu_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SRL:  alu_res = A >> shamt;
            OP_SLL:  alu_res = A << shamt;
            OP_SRA:  alu_res = $signed(A) >>> shamt;
            // Multicycle codes only reach here when the iterative unit is absent.
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             md_load, md_step, md_last;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk  (clk),
        .rst  (rst),
        .load (md_load),
        .mode ((op == OP_MUL) ? MODE_MUL : MODE_DIV),
        .A    (A),
        .B    (B),
        .step (md_step),
        .lo   (md_lo),
        .hi   (md_hi),
        .last (md_last)
    );
    assign md_step = (state_q == S_RUN);
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        co_d    = co_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        done_d  = 1'b0;
`ifdef ALU_MULDIV_EN
        op_d    = op_q;
        md_load = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_MULDIV_EN
                    if (is_multicycle(op)) begin
                        state_d = S_RUN;
                        op_d    = op;
                        md_load = 1'b1;
                    end else
`endif
                    begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        res_d   = alu_res;
                        co_d    = alu_co;
                        ovf_d   = alu_ovf;
                        ill_d   = alu_ill;
                        zero_d  = (alu_res == '0);
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            S_RUN: begin
                // md_lo/md_hi already include this cycle's final step.
                if (md_last) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    res_d   = (op_q == OP_REMU) ? md_hi : md_lo;
                    co_d    = 1'b0;
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                    zero_d  = (res_d == '0);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            done_q  <= 1'b0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
            op_q    <= OP_AND;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            done_q  <= done_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
`ifdef ALU_MULDIV_EN
            op_q    <= op_d;
`endif
        end
    end

`ifdef ALU_MULDIV_EN
    assign busy = (state_q == S_RUN);
`else
    assign busy = 1'b0;
`endif
    assign done     = done_q;
    assign res      = res_q;
    assign Co       = co_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign illegal  = ill_q;

endmodule
